// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the memory bus controller: state encoding, default
// internal-memory window and timeout, and the latched request payload.
package mem_bus_ctrl_pkg;

   localparam int unsigned DW            = 32;
   localparam logic [31:0] DEF_INT_BASE  = 32'h0000_1730;
   localparam int unsigned DEF_INT_AW    = 10;
   localparam int unsigned DEF_TIMEOUT   = 16;

   // Address decoder window for internal memory; the decoder uses the same limits
   localparam logic [31:0] DEC_WIN_LO    = 32'h0000_1730;
   localparam logic [31:0] DEC_WIN_HI    = 32'h0000_1B2F;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_INT_ACC  = 3'd1,
      ST_INT_RD   = 3'd2,
      ST_EXT_WAIT = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   typedef struct packed {
      logic          we;
      logic [DW-1:0] addr;
      logic [DW-1:0] wdata;
   } bus_req_t;

endpackage

// File: rtl/bus_timeout_cnt.sv
// External-access timeout counter: cleared on EXT_WAIT entry, counts while
// waiting, flags the last allowed wait cycle.
module bus_timeout_cnt
   import mem_bus_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired_c
);

   localparam int unsigned CW = $clog2(TIMEOUT);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign expired_c = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: sequences CPU loads/stores to the internal sync RAM
// or the external req/ack bus, with timeout, done pulse and busy stall.
module mem_bus_ctrl
   import mem_bus_ctrl_pkg::*;
#(
   parameter logic [31:0] INT_BASE = DEF_INT_BASE,
   parameter int unsigned INT_AW   = DEF_INT_AW,
   parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [DW-1:0]     cpu_addr,
   input  logic [DW-1:0]     cpu_wdata,
   input  logic              cs,
   output logic [DW-1:0]     cpu_rdata,
   output logic              done,
   output logic              err,
   output logic              busy,
   output logic              int_en,
   output logic              int_we,
   output logic [INT_AW-1:0] int_addr,
   output logic [DW-1:0]     int_wdata,
   input  logic [DW-1:0]     int_rdata,
   output logic              ext_req,
   output logic              ext_we,
   output logic [DW-1:0]     ext_addr,
   output logic [DW-1:0]     ext_wdata,
   input  logic [DW-1:0]     ext_rdata,
   input  logic              ext_ack
);

   state_t        state, state_nxt;
   bus_req_t      lat_q, req_sel;
   logic [DW-1:0] rdata_nxt;
   logic          rd_load, err_nxt, cnt_clr, expired_c;

   bus_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (cnt_clr),
      .en        (state == ST_EXT_WAIT),
      .expired_c (expired_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next state, read-register update and request source for the output stage
   always_comb begin
      state_nxt = state;
      rd_load   = 1'b0;
      rdata_nxt = '0;
      err_nxt   = 1'b0;
      cnt_clr   = 1'b0;
      req_sel   = lat_q;
      case (state)
         ST_IDLE: begin
            req_sel = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
            if (cpu_req) begin
               state_nxt = cs ? ST_EXT_WAIT : ST_INT_ACC;
               cnt_clr   = cs;
            end
         end
         ST_INT_ACC: state_nxt = ST_INT_RD;
         ST_INT_RD: begin
            rd_load   = 1'b1;
            rdata_nxt = lat_q.we ? '0 : int_rdata;
            state_nxt = ST_DONE;
         end
         ST_EXT_WAIT: begin
            // Ack wins over a coincident timeout
            if (ext_ack) begin
               rd_load   = 1'b1;
               rdata_nxt = lat_q.we ? '0 : ext_rdata;
               state_nxt = ST_DONE;
            end else if (expired_c) begin
               rd_load   = 1'b1;
               err_nxt   = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_q <= '0;
      end else if (state == ST_IDLE && cpu_req) begin
         lat_q <= req_sel;
      end
   end

   // Registered outputs, decoded from the next state so they align with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_rdata <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
         int_en    <= 1'b0;
         int_we    <= 1'b0;
         int_addr  <= '0;
         int_wdata <= '0;
         ext_req   <= 1'b0;
         ext_we    <= 1'b0;
         ext_addr  <= '0;
         ext_wdata <= '0;
      end else begin
         if (rd_load) cpu_rdata <= rdata_nxt;
         done      <= (state_nxt == ST_DONE);
         err       <= err_nxt;
         busy      <= (state_nxt != ST_IDLE);
         int_en    <= (state_nxt == ST_INT_ACC);
         int_we    <= (state_nxt == ST_INT_ACC) && req_sel.we;
         int_addr  <= (state_nxt == ST_INT_ACC) ? INT_AW'(req_sel.addr - INT_BASE) : '0;
         int_wdata <= (state_nxt == ST_INT_ACC) ? req_sel.wdata : '0;
         ext_req   <= (state_nxt == ST_EXT_WAIT);
         ext_we    <= (state_nxt == ST_EXT_WAIT) && req_sel.we;
         ext_addr  <= (state_nxt == ST_EXT_WAIT) ? req_sel.addr : '0;
         ext_wdata <= (state_nxt == ST_EXT_WAIT) ? req_sel.wdata : '0;
      end
   end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: vector table of single accesses plus
// hand sequences for held requests, busy pulses, late ack and async reset.
module tb_mem_bus_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0, cs = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic [31:0] cpu_rdata;
   logic        done, err, busy;
   logic        int_en, int_we;
   logic [9:0]  int_addr;
   logic [31:0] int_wdata, int_rdata;
   logic        ext_req, ext_we;
   logic [31:0] ext_addr, ext_wdata;
   logic [31:0] ext_rdata = '0;
   logic        ext_ack = 1'b0;

   logic [31:0] ram [0:1023];

   int n_cmp  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   mem_bus_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cs        (cs),
      .cpu_rdata (cpu_rdata),
      .done      (done),
      .err       (err),
      .busy      (busy),
      .int_en    (int_en),
      .int_we    (int_we),
      .int_addr  (int_addr),
      .int_wdata (int_wdata),
      .int_rdata (int_rdata),
      .ext_req   (ext_req),
      .ext_we    (ext_we),
      .ext_addr  (ext_addr),
      .ext_wdata (ext_wdata),
      .ext_rdata (ext_rdata),
      .ext_ack   (ext_ack)
   );

   // Synchronous RAM, one-cycle read latency
   always @(posedge clk) begin
      if (int_en) begin
         if (int_we) ram[int_addr] <= int_wdata;
         else        int_rdata     <= ram[int_addr];
      end
   end

   typedef struct {
      logic        we;
      logic        cs;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          ack_at;
      logic [31:0] ext_data;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_reqcnt;
      logic [9:0]  exp_iaddr;
   } vec_t;

   typedef struct {
      int          lat;
      int          reqcnt;
      int          ien_cnt;
      logic [31:0] rdata;
      logic        err;
      logic [9:0]  iaddr;
      logic        iwe;
      logic [31:0] iwdata;
      logic [31:0] eaddr;
      logic        ewe;
      logic [31:0] ewdata;
   } res_t;

   function automatic vec_t mk(logic we, logic c, logic [31:0] a, logic [31:0] wd, int ack,
                               logic [31:0] ed, logic [31:0] er, logic ee, int el, int erc,
                               logic [9:0] ia);
      vec_t v;
      v.we = we; v.cs = c; v.addr = a; v.wdata = wd; v.ack_at = ack; v.ext_data = ed;
      v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el; v.exp_reqcnt = erc; v.exp_iaddr = ia;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One access: latency counted in cycles after the request edge
   task automatic run_access(input vec_t v, output res_t r);
      r.lat = 0; r.reqcnt = 0; r.ien_cnt = 0; r.rdata = '0; r.err = 1'b0;
      r.iaddr = '0; r.iwe = 1'b0; r.iwdata = '0; r.eaddr = '0; r.ewe = 1'b0; r.ewdata = '0;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = v.we; cs = v.cs; cpu_addr = v.addr; cpu_wdata = v.wdata;
      for (int n = 1; n <= 64; n++) begin
         @(negedge clk);
         cpu_req = 1'b0;
         if (int_en) begin
            r.ien_cnt++; r.iaddr = int_addr; r.iwe = int_we; r.iwdata = int_wdata;
         end
         if (ext_req) begin
            r.reqcnt++;
            if (r.reqcnt == 1) begin
               r.eaddr = ext_addr; r.ewe = ext_we; r.ewdata = ext_wdata;
            end
         end
         ext_ack   = ext_req && (v.ack_at != 0) && (r.reqcnt == v.ack_at);
         ext_rdata = v.ext_data;
         if (done) begin
            r.lat = n; r.rdata = cpu_rdata; r.err = err;
            break;
         end
      end
      ext_ack = 1'b0;
   endtask

   vec_t vecs [11];
   res_t r;
   int   c_en, c_done, c_busy, done_at;

   initial begin
      vecs[0]  = mk(1, 0, 32'h1730, 32'hDEADBEEF, 0,  32'h0,        32'h0,        0, 3,  0,  10'h000);
      vecs[1]  = mk(0, 0, 32'h1730, 32'h0,        0,  32'h0,        32'hDEADBEEF, 0, 3,  0,  10'h000);
      vecs[2]  = mk(1, 0, 32'h1B2F, 32'h12345678, 0,  32'h0,        32'h0,        0, 3,  0,  10'h3FF);
      vecs[3]  = mk(0, 0, 32'h1B2F, 32'h0,        0,  32'h0,        32'h12345678, 0, 3,  0,  10'h3FF);
      vecs[4]  = mk(0, 1, 32'h2000, 32'h0,        4,  32'hCAFEF00D, 32'hCAFEF00D, 0, 5,  4,  10'h000);
      vecs[5]  = mk(1, 1, 32'h3000, 32'h55AA55AA, 1,  32'hFFFFFFFF, 32'h0,        0, 2,  1,  10'h000);
      vecs[6]  = mk(0, 1, 32'h4000, 32'h0,        0,  32'h0,        32'h0,        1, 17, 16, 10'h000);
      vecs[7]  = mk(0, 1, 32'h4004, 32'h0,        16, 32'h0BADF00D, 32'h0BADF00D, 0, 17, 16, 10'h000);
      vecs[8]  = mk(0, 1, 32'h4008, 32'h0,        15, 32'h13572468, 32'h13572468, 0, 16, 15, 10'h000);
      vecs[9]  = mk(1, 0, 32'h1800, 32'hA5A5A5A5, 0,  32'h0,        32'h0,        0, 3,  0,  10'h0D0);
      vecs[10] = mk(0, 0, 32'h1800, 32'h0,        0,  32'h0,        32'hA5A5A5A5, 0, 3,  0,  10'h0D0);

      // Reset state
      #3;
      check("reset ctl", {31'd0, busy | done | err | int_en | int_we | ext_req | ext_we}, 32'd0);
      check("reset cpu_rdata", cpu_rdata, 32'd0);
      check("reset int_addr", {22'd0, int_addr}, 32'd0);
      check("reset int_wdata", int_wdata, 32'd0);
      check("reset ext_addr", ext_addr, 32'd0);
      check("reset ext_wdata", ext_wdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         run_access(vecs[i], r);
         check($sformatf("v%0d latency", i), 32'(r.lat), 32'(vecs[i].exp_lat));
         check($sformatf("v%0d rdata", i), r.rdata, vecs[i].exp_rdata);
         check($sformatf("v%0d err", i), {31'd0, r.err}, {31'd0, vecs[i].exp_err});
         check($sformatf("v%0d ext_req cycles", i), 32'(r.reqcnt), 32'(vecs[i].exp_reqcnt));
         if (!vecs[i].cs) begin
            check($sformatf("v%0d int_en cycles", i), 32'(r.ien_cnt), 32'd1);
            check($sformatf("v%0d int_addr", i), {22'd0, r.iaddr}, {22'd0, vecs[i].exp_iaddr});
            check($sformatf("v%0d int_we", i), {31'd0, r.iwe}, {31'd0, vecs[i].we});
            if (vecs[i].we) check($sformatf("v%0d int_wdata", i), r.iwdata, vecs[i].wdata);
         end else begin
            check($sformatf("v%0d int_en cycles", i), 32'(r.ien_cnt), 32'd0);
            check($sformatf("v%0d ext_addr", i), r.eaddr, vecs[i].addr);
            check($sformatf("v%0d ext_we", i), {31'd0, r.ewe}, {31'd0, vecs[i].we});
            if (vecs[i].we) check($sformatf("v%0d ext_wdata", i), r.ewdata, vecs[i].wdata);
         end
      end

      // cpu_req held high: one internal access per 4 cycles
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cs = 1'b0; cpu_addr = 32'h1730;
      c_en = 0; c_done = 0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (int_en) c_en++;
         if (done) begin
            c_done++;
            check("held req rdata", cpu_rdata, 32'hDEADBEEF);
         end
      end
      cpu_req = 1'b0;
      check("held req int_en count", 32'(c_en), 32'd3);
      check("held req done count", 32'(c_done), 32'd3);
      repeat (4) @(negedge clk);

      // Request pulse while busy with an external access is dropped
      cpu_req = 1'b1; cpu_we = 1'b0; cs = 1'b1; cpu_addr = 32'h5000;
      ext_rdata = 32'h600DCAFE;
      c_en = 0; c_done = 0; done_at = 0;
      begin
         int rc;
         rc = 0;
         for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            cpu_req = (n == 2);
            if (n == 2) cs = 1'b0;
            if (ext_req) rc++;
            ext_ack = ext_req && (rc == 6);
            if (int_en) c_en++;
            if (done) begin
               c_done++; done_at = n;
               check("busy pulse rdata", cpu_rdata, 32'h600DCAFE);
            end
         end
      end
      cpu_req = 1'b0; ext_ack = 1'b0;
      check("busy pulse int_en count", 32'(c_en), 32'd0);
      check("busy pulse done count", 32'(c_done), 32'd1);
      check("busy pulse done cycle", 32'(done_at), 32'd7);

      // Timeout followed by a late ack that must be ignored
      run_access(vecs[6], r);
      check("late ack timeout err", {31'd0, r.err}, 32'd1);
      c_done = 0; c_busy = 0;
      ext_rdata = 32'hFFFF0000;
      for (int n = 1; n <= 3; n++) begin
         ext_ack = (n <= 2);
         @(negedge clk);
         if (done) c_done++;
         if (busy) c_busy++;
      end
      ext_ack = 1'b0;
      check("late ack done count", 32'(c_done), 32'd0);
      check("late ack busy count", 32'(c_busy), 32'd0);
      check("late ack rdata", cpu_rdata, 32'd0);

      // Async reset in the middle of EXT_WAIT
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cs = 1'b1; cpu_addr = 32'h6000;
      repeat (5) begin
         @(negedge clk);
         cpu_req = 1'b0;
      end
      check("pre-reset ext_req", {31'd0, ext_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async reset ext_req", {31'd0, ext_req}, 32'd0);
      check("async reset busy", {31'd0, busy}, 32'd0);
      check("async reset ext_addr", ext_addr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_access(mk(0, 1, 32'h2400, 32'h0, 2, 32'h11112222, 32'h11112222, 0, 3, 2, 10'h0), r);
      check("post-reset latency", 32'(r.lat), 32'd3);
      check("post-reset rdata", r.rdata, 32'h11112222);
      check("post-reset err", {31'd0, r.err}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
      $finish;
   end

endmodule
